// File: rtl/frame_receive_arbiter_pkg.sv
// Shared definitions for the switch receive path.
// Provides the byte width, end-of-frame bit position, the arbiter state
// encoding and a one-hot to index helper used by the receive arbiter.
package switch_package;

    localparam int SWITCH_DATA_WIDTH = 9;
    localparam int END_OF_FRAME_BIT  = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRANSFER = 2'd1,
        DRAIN    = 2'd2
    } arbiter_state_t;

    // Index of the set bit in a one-hot vector of up to 16 bits; 0 when empty.
    function automatic logic [3:0] onehot_to_index(input logic [15:0] onehot);
        logic [3:0] index;
        index = '0;
        for (int i = 0; i < 16; i++) begin
            if (onehot[i[3:0]]) begin
                index = i[3:0];
            end
        end
        return index;
    endfunction

endpackage

// File: rtl/frame_receive_arbiter_if.sv
// Bundle of the receive-side handshake signals of the frame receive arbiter.
//   port_receive_data_valid / port_receive_data / port_receive_data_ready :
//       per-port byte streams coming from the RMII port receive queues
//   frame_data / frame_data_valid / frame_data_ready :
//       single merged byte stream towards the switch core
//   frame_source_port / frame_start / frame_truncated :
//       frame side-band information
// master = arbiter side, slave = environment side.
interface frame_receive_arbiter_if #(
    parameter int NUMBER_OF_PORTS = 2
);
    import switch_package::*;

    localparam int INDEX_WIDTH = $clog2(NUMBER_OF_PORTS);

    logic [NUMBER_OF_PORTS-1:0]                        port_receive_data_valid;
    logic [NUMBER_OF_PORTS-1:0][SWITCH_DATA_WIDTH-1:0] port_receive_data;
    logic [NUMBER_OF_PORTS-1:0]                        port_receive_data_ready;
    logic [SWITCH_DATA_WIDTH-1:0]                      frame_data;
    logic                                              frame_data_valid;
    logic                                              frame_data_ready;
    logic [INDEX_WIDTH-1:0]                            frame_source_port;
    logic                                              frame_start;
    logic                                              frame_truncated;

    modport master (
        input  port_receive_data_valid,
        input  port_receive_data,
        output port_receive_data_ready,
        output frame_data,
        output frame_data_valid,
        input  frame_data_ready,
        output frame_source_port,
        output frame_start,
        output frame_truncated
    );

    modport slave (
        output port_receive_data_valid,
        output port_receive_data,
        input  port_receive_data_ready,
        input  frame_data,
        input  frame_data_valid,
        output frame_data_ready,
        input  frame_source_port,
        input  frame_start,
        input  frame_truncated
    );

endinterface

// File: rtl/frame_receive_arbiter_rr.sv
// Combinational round-robin arbiter.
//   request : per-port request vector
//   pointer : index of the last granted port; search starts one above it
//   grant   : one-hot grant of the first requester found, zero if none
module round_robin_arbiter #(
    parameter int NUMBER_OF_PORTS = 2
) (
    input  logic [NUMBER_OF_PORTS-1:0]         request,
    input  logic [$clog2(NUMBER_OF_PORTS)-1:0] pointer,
    output logic [NUMBER_OF_PORTS-1:0]         grant
);

    localparam int INDEX_WIDTH = $clog2(NUMBER_OF_PORTS);

    logic [INDEX_WIDTH-1:0] candidate;
    logic                   found;

    always_comb begin
        grant     = '0;
        found     = 1'b0;
        candidate = '0;
        for (int offset = 1; offset <= NUMBER_OF_PORTS; offset++) begin
            candidate = INDEX_WIDTH'((int'(pointer) + offset) % NUMBER_OF_PORTS);
            if (!found && request[candidate]) begin
                grant[candidate] = 1'b1;
                found            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_receive_arbiter.sv
// Frame receive arbiter: merges the receive byte streams of several RMII
// ports into one frame stream, one whole frame at a time, round-robin.
//   clock : sole clock, rising edge
//   reset : synchronous, active high
//   bus   : master side of frame_receive_arbiter_if (port streams in,
//           merged frame stream and side-band out)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no grant; pick next requesting port round-robin
// TRANSFER | forward bytes of the granted port until end-of-frame or cut
// DRAIN    | wait for the last forwarded byte to be consumed downstream
module frame_receive_arbiter
    import switch_package::*;
#(
    parameter int NUMBER_OF_PORTS = 2,
    parameter int MAX_FRAME_BYTES = 1522
) (
    input  logic                     clock,
    input  logic                     reset,
    frame_receive_arbiter_if.master  bus
);

    localparam int          INDEX_WIDTH = $clog2(NUMBER_OF_PORTS);
    localparam logic [10:0] MAX_COUNT   = 11'(MAX_FRAME_BYTES);

    arbiter_state_t               state;
    arbiter_state_t               next_state;
    logic [INDEX_WIDTH-1:0]       last_grant;
    logic [INDEX_WIDTH-1:0]       granted_port;
    logic [10:0]                  byte_count;
    logic                         first_byte_pending;
    logic [NUMBER_OF_PORTS-1:0]   grant_onehot;
    logic [NUMBER_OF_PORTS-1:0]   ready;
    logic [SWITCH_DATA_WIDTH-1:0] accepted_byte;
    logic [SWITCH_DATA_WIDTH-1:0] forwarded_byte;
    logic [SWITCH_DATA_WIDTH-1:0] out_byte;
    logic                         out_valid;
    logic                         out_start;
    logic                         out_truncated;
    logic                         any_request;
    logic                         output_free;
    logic                         consume;
    logic                         accept;
    logic                         end_of_frame;
    logic                         cut_frame;

    round_robin_arbiter #(
        .NUMBER_OF_PORTS(NUMBER_OF_PORTS)
    ) u_round_robin_arbiter (
        .request (bus.port_receive_data_valid),
        .pointer (last_grant),
        .grant   (grant_onehot)
    );

    assign any_request   = |bus.port_receive_data_valid;
    assign output_free   = !out_valid || bus.frame_data_ready;
    assign consume       = out_valid && bus.frame_data_ready;
    assign accepted_byte = bus.port_receive_data[granted_port];
    // Reset gates acceptance so a source never sees its byte taken by a
    // transfer that reset is about to throw away.
    assign accept        = (state == TRANSFER) && output_free && !reset
                           && bus.port_receive_data_valid[granted_port];
    assign end_of_frame  = accepted_byte[END_OF_FRAME_BIT];
    assign cut_frame     = !end_of_frame && ((byte_count + 11'd1) == MAX_COUNT);

    always_comb begin
        ready = '0;
        if ((state == TRANSFER) && output_free && !reset) begin
            ready[granted_port] = 1'b1;
        end
    end

    // A cut frame is closed downstream by forcing the end-of-frame flag.
    always_comb begin
        forwarded_byte = accepted_byte;
        if (cut_frame) begin
            forwarded_byte[END_OF_FRAME_BIT] = 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (any_request) begin
                    next_state = TRANSFER;
                end
            end
            TRANSFER: begin
                if (accept && (end_of_frame || cut_frame)) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (!out_valid || consume) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant         <= INDEX_WIDTH'(NUMBER_OF_PORTS - 1);
            granted_port       <= '0;
            byte_count         <= '0;
            first_byte_pending <= 1'b0;
            out_byte           <= '0;
            out_valid          <= 1'b0;
            out_start          <= 1'b0;
            out_truncated      <= 1'b0;
        end else begin
            out_truncated <= 1'b0;

            if ((state == IDLE) && any_request) begin
                granted_port       <= INDEX_WIDTH'(onehot_to_index(16'(grant_onehot)));
                byte_count         <= '0;
                first_byte_pending <= 1'b1;
            end

            if (accept) begin
                out_byte           <= forwarded_byte;
                out_valid          <= 1'b1;
                out_start          <= first_byte_pending;
                first_byte_pending <= 1'b0;
                byte_count         <= byte_count + 11'd1;
                out_truncated      <= cut_frame;
            end else if (consume) begin
                out_valid <= 1'b0;
                out_start <= 1'b0;
            end

            if ((state == DRAIN) && (next_state == IDLE)) begin
                last_grant <= granted_port;
            end
        end
    end

    assign bus.port_receive_data_ready = ready;
    assign bus.frame_data              = out_byte;
    assign bus.frame_data_valid        = out_valid;
    assign bus.frame_source_port       = granted_port;
    assign bus.frame_start             = out_start;
    assign bus.frame_truncated         = out_truncated;

endmodule

// File: tb/tb_frame_receive_arbiter.sv
module tb_frame_receive_arbiter;
    import switch_package::*;

    localparam int PORTS     = 2;
    localparam int MAX_BYTES = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;

    frame_receive_arbiter_if #(.NUMBER_OF_PORTS(PORTS)) bus ();

    frame_receive_arbiter #(
        .NUMBER_OF_PORTS (PORTS),
        .MAX_FRAME_BYTES (MAX_BYTES)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    logic       drv_valid [PORTS];
    logic [8:0] drv_data  [PORTS];
    logic       sink_ready;

    assign bus.port_receive_data_valid = {drv_valid[1], drv_valid[0]};
    assign bus.port_receive_data       = {drv_data[1], drv_data[0]};
    assign bus.frame_data_ready        = sink_ready;

    int checks = 0;
    int errors = 0;
    int trunc_count = 0;
    logic [10:0] out_q [$];
    logic [10:0] expect_q [$];

    // Downstream monitor: {frame_start, frame_source_port, frame_data} per consumed byte.
    always @(posedge clock) begin
        if (bus.frame_data_valid && bus.frame_data_ready) begin
            out_q.push_back({bus.frame_start, bus.frame_source_port, bus.frame_data});
        end
        if (bus.frame_truncated) begin
            trunc_count <= trunc_count + 1;
        end
    end

    function automatic logic [10:0] entry(input logic start, input logic src, input logic [8:0] data);
        return {start, src, data};
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic compare_output(input string tag, input int base);
        int got;
        got = out_q.size() - base;
        check({tag, "_count"}, got, expect_q.size());
        for (int i = 0; i < expect_q.size(); i++) begin
            if (i < got) begin
                check(tag, out_q[base + i], expect_q[i]);
            end
        end
        expect_q.delete();
    endtask

    // Drives one frame on a port, holding each byte until the arbiter takes it.
    task automatic send_frame(input int port, input int count, input logic [7:0] first,
                              input logic [7:0] step, input logic eof);
        logic [7:0] d;
        logic       accepted;
        logic       abort;
        d     = first;
        abort = 1'b0;
        for (int i = 0; i < count && !abort; i++) begin
            drv_valid[port] = 1'b1;
            drv_data[port]  = {eof && (i == count - 1), d};
            accepted = 1'b0;
            for (int t = 0; t < 200 && !accepted; t++) begin
                @(negedge clock);
                accepted = bus.port_receive_data_ready[port];
                @(posedge clock);
                #1;
            end
            if (!accepted) begin
                check("send_accept", accepted, 1);
                abort = 1'b1;
            end else begin
                check("accept_latency", bus.frame_data[7:0], d);
            end
            d = d + step;
        end
        drv_valid[port] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int tbefore;
        drv_valid[0] = 1'b0;
        drv_valid[1] = 1'b0;
        drv_data[0]  = '0;
        drv_data[1]  = '0;
        sink_ready   = 1'b1;

        // Reset state
        reset = 1'b1;
        tick;
        tick;
        check("reset_ready", bus.port_receive_data_ready, 2'b00);
        check("reset_data", bus.frame_data, 9'h000);
        check("reset_valid", bus.frame_data_valid, 1'b0);
        check("reset_start", bus.frame_start, 1'b0);
        check("reset_trunc", bus.frame_truncated, 1'b0);
        check("reset_src", bus.frame_source_port, 1'b0);
        reset = 1'b0;
        tick;

        // Single port frame, continuous downstream ready
        base = out_q.size();
        send_frame(0, 4, 8'h11, 8'h11, 1'b1);
        repeat (3) tick;
        expect_q.push_back(entry(1'b1, 1'b0, 9'h011));
        expect_q.push_back(entry(1'b0, 1'b0, 9'h022));
        expect_q.push_back(entry(1'b0, 1'b0, 9'h033));
        expect_q.push_back(entry(1'b0, 1'b0, 9'h144));
        compare_output("single_frame", base);

        // Two ports competing; port 0 was served last so port 1 leads
        base = out_q.size();
        fork
            begin
                send_frame(0, 2, 8'hA1, 8'h01, 1'b1);
                send_frame(0, 2, 8'hC1, 8'h01, 1'b1);
            end
            begin
                send_frame(1, 2, 8'hB1, 8'h01, 1'b1);
                send_frame(1, 2, 8'hD1, 8'h01, 1'b1);
            end
        join
        repeat (3) tick;
        expect_q.push_back(entry(1'b1, 1'b1, 9'h0B1));
        expect_q.push_back(entry(1'b0, 1'b1, 9'h1B2));
        expect_q.push_back(entry(1'b1, 1'b0, 9'h0A1));
        expect_q.push_back(entry(1'b0, 1'b0, 9'h1A2));
        expect_q.push_back(entry(1'b1, 1'b1, 9'h0D1));
        expect_q.push_back(entry(1'b0, 1'b1, 9'h1D2));
        expect_q.push_back(entry(1'b1, 1'b0, 9'h0C1));
        expect_q.push_back(entry(1'b0, 1'b0, 9'h1C2));
        compare_output("round_robin", base);

        // Downstream stall for 5 cycles mid-frame
        base = out_q.size();
        fork
            send_frame(0, 6, 8'h51, 8'h01, 1'b1);
            begin
                int waited;
                waited = 0;
                while (out_q.size() < base + 2 && waited < 100) begin
                    tick;
                    waited++;
                end
                if (out_q.size() < base + 2) begin
                    check("stall_wait", out_q.size() - base, 2);
                end
                sink_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    #1;
                    check("stall_hold_data", bus.frame_data, 9'h053);
                    check("stall_hold_valid", bus.frame_data_valid, 1'b1);
                    check("stall_ready_low", bus.port_receive_data_ready, 2'b00);
                    tick;
                end
                sink_ready = 1'b1;
            end
        join
        repeat (3) tick;
        expect_q.push_back(entry(1'b1, 1'b0, 9'h051));
        expect_q.push_back(entry(1'b0, 1'b0, 9'h052));
        expect_q.push_back(entry(1'b0, 1'b0, 9'h053));
        expect_q.push_back(entry(1'b0, 1'b0, 9'h054));
        expect_q.push_back(entry(1'b0, 1'b0, 9'h055));
        expect_q.push_back(entry(1'b0, 1'b0, 9'h156));
        compare_output("stall", base);
        check("no_trunc_before", trunc_count, 0);

        // Watchdog cut at 8 bytes; remainder is a new frame
        base    = out_q.size();
        tbefore = trunc_count;
        send_frame(1, 10, 8'h61, 8'h01, 1'b0);
        repeat (3) tick;
        expect_q.push_back(entry(1'b1, 1'b1, 9'h061));
        expect_q.push_back(entry(1'b0, 1'b1, 9'h062));
        expect_q.push_back(entry(1'b0, 1'b1, 9'h063));
        expect_q.push_back(entry(1'b0, 1'b1, 9'h064));
        expect_q.push_back(entry(1'b0, 1'b1, 9'h065));
        expect_q.push_back(entry(1'b0, 1'b1, 9'h066));
        expect_q.push_back(entry(1'b0, 1'b1, 9'h067));
        expect_q.push_back(entry(1'b0, 1'b1, 9'h168));
        expect_q.push_back(entry(1'b1, 1'b1, 9'h069));
        expect_q.push_back(entry(1'b0, 1'b1, 9'h06A));
        compare_output("truncate", base);
        check("truncate_pulses", trunc_count - tbefore, 1);

        // Reset while port 1 offers the 3rd byte of its open frame
        reset        = 1'b1;
        drv_valid[1] = 1'b1;
        drv_data[1]  = 9'h07B;
        tick;
        check("midreset_state", dut.state, IDLE);
        check("midreset_ready", bus.port_receive_data_ready, 2'b00);
        check("midreset_data", bus.frame_data, 9'h000);
        check("midreset_valid", bus.frame_data_valid, 1'b0);
        check("midreset_start", bus.frame_start, 1'b0);
        check("midreset_trunc", bus.frame_truncated, 1'b0);
        check("midreset_src", bus.frame_source_port, 1'b0);
        reset        = 1'b0;
        drv_valid[0] = 1'b1;
        drv_data[0]  = 9'h1E1;
        tick;
        check("post_reset_grant_src", bus.frame_source_port, 1'b0);
        check("post_reset_grant_ready", bus.port_receive_data_ready, 2'b01);
        tick;
        check("post_reset_data", bus.frame_data, 9'h1E1);
        check("post_reset_valid", bus.frame_data_valid, 1'b1);
        check("post_reset_start", bus.frame_start, 1'b1);
        drv_valid[0] = 1'b0;
        tick;
        tick;
        check("next_grant_src", bus.frame_source_port, 1'b1);
        check("next_grant_ready", bus.port_receive_data_ready, 2'b10);
        drv_valid[1] = 1'b0;
        repeat (2) tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
